// File: rtl/ysyx_041514_pipe_skid_reg_pkg.sv
// rtl/ysyx_041514_pipe_skid_reg_pkg.sv - shared widths, occupancy codes and entry ops for pipeline stage registers
package ysyx_041514_pipe_skid_reg_pkg;

  // Stage widths used by instantiating stages to build DATA_W and RESET_DATA
  localparam int XLEN     = 64;
  localparam int INST_LEN = 32;
  localparam int TRAP_LEN = 4;
  localparam logic [INST_LEN-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_TWO   = 2'd2;

  typedef enum logic [1:0] {
    MAIN_HOLD      = 2'd0,
    MAIN_LOAD_IN   = 2'd1,
    MAIN_LOAD_SKID = 2'd2,
    MAIN_CLEAR     = 2'd3
  } main_op_e;

  function automatic logic ready_from_count(input logic [1:0] cnt);
    return cnt != CNT_TWO;
  endfunction

endpackage

// File: rtl/ysyx_041514_pipe_entry.sv
// rtl/ysyx_041514_pipe_entry.sv - payload register with write enable and clear-to-bubble
module ysyx_041514_pipe_entry #(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      q <= RESET_DATA;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx_041514_pipe_skid_reg.sv
// rtl/ysyx_041514_pipe_skid_reg.sv - valid/ready stage register with optional skid entry and bubble payload
module ysyx_041514_pipe_skid_reg
  import ysyx_041514_pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}},
  parameter bit                SKID_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count_o
);

  logic [1:0]        count_q;
  logic [1:0]        count_d;
  main_op_e          main_op;
  logic              skid_we;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  assign out_valid = (count_q != CNT_EMPTY);
  assign out_data  = main_q;
  assign count_o   = count_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // main always holds the head; skid only ever holds the second-oldest payload
  always_comb begin
    count_d = count_q;
    main_op = MAIN_HOLD;
    skid_we = 1'b0;
    if (flush_i) begin
      count_d = CNT_EMPTY;
      main_op = MAIN_CLEAR;
    end else begin
      case (count_q)
        CNT_EMPTY: begin
          if (in_fire) begin
            count_d = CNT_ONE;
            main_op = MAIN_LOAD_IN;
          end
        end
        CNT_ONE: begin
          if (in_fire && out_fire) begin
            main_op = MAIN_LOAD_IN;
          end else if (in_fire) begin
            if (SKID_EN) begin
              count_d = CNT_TWO;
              skid_we = 1'b1;
            end
          end else if (out_fire) begin
            count_d = CNT_EMPTY;
            main_op = MAIN_CLEAR;
          end
        end
        CNT_TWO: begin
          if (out_fire) begin
            count_d = CNT_ONE;
            main_op = MAIN_LOAD_SKID;
          end
        end
        default: begin
          count_d = CNT_EMPTY;
          main_op = MAIN_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= CNT_EMPTY;
    end else begin
      count_q <= count_d;
    end
  end

  assign main_d = (main_op == MAIN_LOAD_SKID) ? skid_q : in_data;

  ysyx_041514_pipe_entry #(
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .clr (main_op == MAIN_CLEAR),
    .we  ((main_op == MAIN_LOAD_IN) || (main_op == MAIN_LOAD_SKID)),
    .d   (main_d),
    .q   (main_q)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic ready_q;

      ysyx_041514_pipe_entry #(
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
      ) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (flush_i),
        .we  (skid_we),
        .d   (in_data),
        .q   (skid_q)
      );

      // Registered ready: derived from the next occupancy, so upstream never sees a comb path
      always_ff @(posedge clk) begin
        if (!rst) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= ready_from_count(count_d);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      assign skid_q   = RESET_DATA;
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_ysyx_041514_pipe_skid_reg.sv
// tb/tb_ysyx_041514_pipe_skid_reg.sv - directed vector bench for the skid stage register
module tb_ysyx_041514_pipe_skid_reg;

  localparam int DW = 96;
  localparam logic [DW-1:0] R = 96'h0000_0000_0000_0000_0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    count1, count0;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  ysyx_041514_pipe_skid_reg #(.DATA_W(DW), .RESET_DATA(R), .SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count_o(count1)
  );

  ysyx_041514_pipe_skid_reg #(.DATA_W(DW), .RESET_DATA(R), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .count_o(count0)
  );

  typedef struct {
    logic          sel;
    logic          rst;
    logic          flush;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          eov;
    logic [DW-1:0] eod;
    logic          eir;
    logic [1:0]    ecnt;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic sel, input logic r, input logic f, input logic iv,
                              input logic [DW-1:0] d, input logic ordy, input logic eov,
                              input logic [DW-1:0] eod, input logic eir, input logic [1:0] ecnt);
    vec_t v;
    v.sel = sel; v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eir = eir; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; flush = v.flush; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
    #1;
    if (v.sel) begin
      chk("out_valid1", idx, {95'd0, out_valid1}, {95'd0, v.eov});
      chk("out_data1",  idx, out_data1, v.eod);
      chk("in_ready1",  idx, {95'd0, in_ready1}, {95'd0, v.eir});
      chk("count1",     idx, {94'd0, count1}, {94'd0, v.ecnt});
    end else begin
      chk("out_valid0", idx, {95'd0, out_valid0}, {95'd0, v.eov});
      chk("out_data0",  idx, out_data0, v.eod);
      chk("in_ready0",  idx, {95'd0, in_ready0}, {95'd0, v.eir});
      chk("count0",     idx, {94'd0, count0}, {94'd0, v.ecnt});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    do_reset();

    // skid instance: stream, backpressure fill, flush, drain, reset mid-transfer, reset at full
    tab.push_back(mk(1, 1, 0, 1, 96'h1,  1, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 1, 96'h2,  1, 1, 96'h1,  1, 1));
    tab.push_back(mk(1, 1, 0, 1, 96'h3,  1, 1, 96'h2,  1, 1));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  1, 1, 96'h3,  1, 1));
    tab.push_back(mk(1, 1, 0, 1, 96'hA,  0, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 1, 96'hB,  0, 1, 96'hA,  1, 1));
    tab.push_back(mk(1, 1, 0, 1, 96'hC,  0, 1, 96'hA,  0, 2));
    tab.push_back(mk(1, 1, 0, 1, 96'hC,  1, 1, 96'hA,  0, 2));
    tab.push_back(mk(1, 1, 0, 1, 96'hC,  1, 1, 96'hB,  1, 1));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  1, 1, 96'hC,  1, 1));
    tab.push_back(mk(1, 1, 0, 1, 96'h11, 0, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 1, 96'h12, 0, 1, 96'h11, 1, 1));
    tab.push_back(mk(1, 1, 1, 1, 96'hD,  0, 1, 96'h11, 0, 2));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  1, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 1, 1, 96'hE,  1, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  1, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 1, 96'h5,  1, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  1, 1, 96'h5,  1, 1));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  1, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 1, 96'h21, 0, 0, R,      1, 0));
    tab.push_back(mk(1, 0, 0, 1, 96'h22, 0, 1, 96'h21, 1, 1));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  0, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 1, 96'h31, 0, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 1, 96'h32, 0, 1, 96'h31, 1, 1));
    tab.push_back(mk(1, 0, 0, 0, 96'h0,  1, 1, 96'h31, 0, 2));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  1, 0, R,      1, 0));
    // flush at full with out_fire: out_fire honoured, nothing kept
    tab.push_back(mk(1, 1, 0, 1, 96'h41, 0, 0, R,      1, 0));
    tab.push_back(mk(1, 1, 0, 1, 96'h42, 0, 1, 96'h41, 1, 1));
    tab.push_back(mk(1, 1, 1, 0, 96'h0,  1, 1, 96'h41, 0, 2));
    tab.push_back(mk(1, 1, 0, 0, 96'h0,  1, 0, R,      1, 0));
    foreach (tab[i]) apply(tab[i], i);

    // single-register instance
    do_reset();
    tab.delete();
    tab.push_back(mk(0, 1, 0, 1, 96'h51, 0, 0, R,      1, 0));
    tab.push_back(mk(0, 1, 0, 1, 96'h52, 0, 1, 96'h51, 0, 1));
    tab.push_back(mk(0, 1, 0, 1, 96'h52, 0, 1, 96'h51, 0, 1));
    tab.push_back(mk(0, 1, 0, 1, 96'h52, 1, 1, 96'h51, 1, 1));
    tab.push_back(mk(0, 1, 0, 1, 96'h53, 1, 1, 96'h52, 1, 1));
    tab.push_back(mk(0, 1, 0, 0, 96'h0,  1, 1, 96'h53, 1, 1));
    tab.push_back(mk(0, 1, 0, 0, 96'h0,  0, 0, R,      1, 0));
    tab.push_back(mk(0, 1, 0, 1, 96'h54, 0, 0, R,      1, 0));
    tab.push_back(mk(0, 1, 1, 0, 96'h0,  0, 1, 96'h54, 0, 1));
    tab.push_back(mk(0, 1, 0, 0, 96'h0,  0, 0, R,      1, 0));
    foreach (tab[i]) apply(tab[i], 100 + i);

    // ordering under random backpressure on the skid instance, with a queue reference
    do_reset();
    begin
      logic [DW-1:0] q[$];
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic [DW-1:0] exp_head;
      while (got < 20 && cyc < 400) begin
        @(negedge clk);
        in_valid  = (sent < 20);
        in_data   = 96'h1000 + DW'(sent);
        out_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (count1 == 2'd3) chk("count1_range", cyc, {94'd0, count1}, 96'd2);
        if (out_valid1 && out_ready) begin
          if (q.size() == 0) begin
            chk("order_spurious", got, out_data1, R);
          end else begin
            exp_head = q.pop_front();
            chk("order", got, out_data1, exp_head);
          end
          got++;
        end
        if (in_valid && in_ready1) begin
          q.push_back(in_data);
          sent++;
        end
        cyc++;
      end
      if (got < 20) begin
        vecs++;
        miss++;
        $display("FAIL order_timeout: got %0d payloads want 20", got);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("drained_count", 0, {94'd0, count1}, 96'd0);
      chk("drained_data",  0, out_data1, R);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
